// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package  : uart_pkg
// Brief    : Shared UART FSM state encoding and parity-type constants (TX/RX).
// Revision : 1.0
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam logic c_PARITY_EVEN = 1'b0;
    localparam logic c_PARITY_ODD  = 1'b1;

    // Even parity is the plain XOR of the data bits; odd parity is its inverse.
    function automatic logic parity_bit(input logic data_xor, input logic parity_type);
        return (parity_type == c_PARITY_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_serializer
// Brief    : Bit prescaler, data shift register and bit index for the UART TX.
// Revision : 1.0
// ============================================================================
module uart_tx_serializer #(
    parameter int Data_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_load,
    input  logic [Data_WIDTH-1:0] i_data,
    input  logic                  i_run,
    input  logic                  i_shift,
    output logic                  o_bit_tick,
    output logic                  o_last_bit,
    output logic                  o_cur_bit,
    output logic                  o_next_bit
);

    localparam int c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_IDX_W = (Data_WIDTH > 1) ? $clog2(Data_WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(Data_WIDTH - 1);

    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_IDX_W-1:0]    r_idx;
    logic [Data_WIDTH-1:0] r_shift;

    // Prescaler restarts at every bit boundary and stays parked while idle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load || !i_run || (r_cnt == c_CNT_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift <= '0;
            r_idx   <= '0;
        end else if (i_load) begin
            r_shift <= i_data;
            r_idx   <= '0;
        end else if (i_shift) begin
            r_shift <= r_shift >> 1;
            r_idx   <= r_idx + 1'b1;
        end
    end

    assign o_bit_tick = i_run && (r_cnt == c_CNT_LAST);
    assign o_last_bit = (r_idx == c_IDX_LAST);
    assign o_cur_bit  = r_shift[0];

    generate
        if (Data_WIDTH > 1) begin : g_next_bit
            assign o_next_bit = r_shift[1];
        end else begin : g_single_bit
            assign o_next_bit = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_ctrl
// Brief    : UART transmitter FSM with optional even/odd parity bit.
// Revision : 1.0
// ============================================================================
module uart_tx_ctrl #(
    parameter int Data_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [Data_WIDTH-1:0] i_data,
    input  logic                  i_data_valid,
    input  logic                  i_parity_enable,
    input  logic                  i_parity_type,
    output logic                  o_tx_out,
    output logic                  o_busy,
    output logic                  o_done
);

    import uart_pkg::*;

    uart_state_t r_state;
    logic        r_parity_en;
    logic        r_parity_bit;
    logic        r_tx;
    logic        r_busy;
    logic        r_done;

    logic w_accept;
    logic w_running;
    logic w_shift;
    logic w_tick;
    logic w_last;
    logic w_cur;
    logic w_next;

    assign w_accept  = (r_state == ST_IDLE) && i_data_valid;
    assign w_running = (r_state != ST_IDLE);
    assign w_shift   = (r_state == ST_DATA) && w_tick && !w_last;

    uart_tx_serializer #(
        .Data_WIDTH   (Data_WIDTH),
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_serializer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_accept),
        .i_data     (i_data),
        .i_run      (w_running),
        .i_shift    (w_shift),
        .o_bit_tick (w_tick),
        .o_last_bit (w_last),
        .o_cur_bit  (w_cur),
        .o_next_bit (w_next)
    );

    // The line value for the next bit is registered on the boundary itself,
    // so o_tx_out changes in the same cycle as the state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_parity_en  <= 1'b0;
            r_parity_bit <= 1'b0;
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_data_valid) begin
                        r_parity_en  <= i_parity_enable;
                        r_parity_bit <= parity_bit(^i_data, i_parity_type);
                        r_state      <= ST_START;
                        r_tx         <= 1'b0;
                        r_busy       <= 1'b1;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        r_state <= ST_DATA;
                        r_tx    <= w_cur;
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        if (!w_last) begin
                            r_tx <= w_next;
                        end else if (r_parity_en) begin
                            r_state <= ST_PARITY;
                            r_tx    <= r_parity_bit;
                        end else begin
                            r_state <= ST_STOP;
                            r_tx    <= 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_tick) begin
                        r_state <= ST_STOP;
                        r_tx    <= 1'b1;
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_tx_out = r_tx;
    assign o_busy   = r_busy;
    assign o_done   = r_done;

endmodule
`default_nettype wire
